// File: rtl/dp_constants_pkg.sv
// Shared constants, TAP state encoding and DMI payload layout for the dp_dtm debug transport.
package dp_constants_pkg;

  localparam int unsigned IR_W   = 5;
  localparam int unsigned DR32_W = 32;
  localparam int unsigned DMI_W  = 41;

  localparam logic [IR_W-1:0] IR_BYPASS_0 = 5'h00;
  localparam logic [IR_W-1:0] IR_IDCODE   = 5'h01;
  localparam logic [IR_W-1:0] IR_DTMCS    = 5'h10;
  localparam logic [IR_W-1:0] IR_DMI      = 5'h11;
  localparam logic [IR_W-1:0] IR_BYPASS   = 5'h1F;
  localparam logic [IR_W-1:0] IR_CAPTURE  = 5'b00001;

  // dtmcs: idle and dmistat are always zero; only version and abits are reported
  localparam logic [3:0]        DTMCS_VERSION = 4'd1;
  localparam logic [5:0]        DTMCS_ABITS   = 6'd7;
  localparam logic [DR32_W-1:0] DTMCS_VALUE   = {22'd0, DTMCS_ABITS, DTMCS_VERSION};

  localparam logic [31:0] IDCODE_DEFAULT = 32'h1000_0CE3;

  typedef enum logic [3:0] {
    TAP_TLR,
    TAP_RTI,
    TAP_SEL_DR,
    TAP_CAP_DR,
    TAP_SH_DR,
    TAP_EX1_DR,
    TAP_PAU_DR,
    TAP_EX2_DR,
    TAP_UPD_DR,
    TAP_SEL_IR,
    TAP_CAP_IR,
    TAP_SH_IR,
    TAP_EX1_IR,
    TAP_PAU_IR,
    TAP_EX2_IR,
    TAP_UPD_IR
  } tap_state_e;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_DTMCS,
    DR_DMI
  } dr_sel_e;

  typedef struct packed {
    logic [6:0]  address;
    logic [31:0] data;
    logic [1:0]  op;
  } dmi_req_t;

endpackage

// File: rtl/dp_tap_fsm.sv
// IEEE 1149.1 16-state TAP controller with decoded capture/shift/update strobes.
module dp_tap_fsm
  import dp_constants_pkg::*;
(
  input  logic       clk,
  input  logic       trst,
  input  logic       tms,
  output tap_state_e state,
  output logic       capture_ir_c,
  output logic       shift_ir_c,
  output logic       update_ir_c,
  output logic       capture_dr_c,
  output logic       shift_dr_c,
  output logic       update_dr_c
);

  tap_state_e state_nxt;

  always_ff @(posedge clk or posedge trst) begin
    if (trst) state <= TAP_TLR;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    capture_ir_c = 1'b0;
    shift_ir_c   = 1'b0;
    update_ir_c  = 1'b0;
    capture_dr_c = 1'b0;
    shift_dr_c   = 1'b0;
    update_dr_c  = 1'b0;
    unique case (state)
      TAP_TLR:    state_nxt = tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:    state_nxt = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR: state_nxt = tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR: begin
        capture_dr_c = 1'b1;
        state_nxt    = tms ? TAP_EX1_DR : TAP_SH_DR;
      end
      TAP_SH_DR: begin
        shift_dr_c = 1'b1;
        state_nxt  = tms ? TAP_EX1_DR : TAP_SH_DR;
      end
      TAP_EX1_DR: state_nxt = tms ? TAP_UPD_DR : TAP_PAU_DR;
      TAP_PAU_DR: state_nxt = tms ? TAP_EX2_DR : TAP_PAU_DR;
      TAP_EX2_DR: state_nxt = tms ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR: begin
        update_dr_c = 1'b1;
        state_nxt   = tms ? TAP_SEL_DR : TAP_RTI;
      end
      TAP_SEL_IR: state_nxt = tms ? TAP_TLR : TAP_CAP_IR;
      TAP_CAP_IR: begin
        capture_ir_c = 1'b1;
        state_nxt    = tms ? TAP_EX1_IR : TAP_SH_IR;
      end
      TAP_SH_IR: begin
        shift_ir_c = 1'b1;
        state_nxt  = tms ? TAP_EX1_IR : TAP_SH_IR;
      end
      TAP_EX1_IR: state_nxt = tms ? TAP_UPD_IR : TAP_PAU_IR;
      TAP_PAU_IR: state_nxt = tms ? TAP_EX2_IR : TAP_PAU_IR;
      TAP_EX2_IR: state_nxt = tms ? TAP_UPD_IR : TAP_SH_IR;
      TAP_UPD_IR: begin
        update_ir_c = 1'b1;
        state_nxt   = tms ? TAP_SEL_DR : TAP_RTI;
      end
    endcase
  end

endmodule

// File: rtl/dp_dtm.sv
// RISC-V JTAG debug transport: IR, BYPASS/IDCODE/DTMCS/DMI registers and DMI request outputs.
// Optional IDCODE register enabled by defining DP_DTM_IDCODE_EN; otherwise reset selects BYPASS.
module dp_dtm
  import dp_constants_pkg::*;
#(
  parameter logic [31:0] IDCODE_VALUE = IDCODE_DEFAULT,
  parameter int unsigned ABITS        = 7
) (
  input  logic             clk,
  input  logic             trst,
  input  logic             tdi,
  input  logic             tms,
  output logic             tdo,
  output logic [ABITS-1:0] dmi_address,
  input  logic [31:0]      dmi_rdata,
  output logic [31:0]      dmi_wdata,
  output logic [1:0]       dmi_op
);

`ifdef DP_DTM_IDCODE_EN
  localparam logic [IR_W-1:0] IR_RESET = IR_IDCODE;
`else
  localparam logic [IR_W-1:0] IR_RESET = IR_BYPASS;
`endif

  tap_state_e       state;
  logic             capture_ir_c, shift_ir_c, update_ir_c;
  logic             capture_dr_c, shift_dr_c, update_dr_c;
  logic [IR_W-1:0]  ir_sr, ir;
  logic [DMI_W-1:0] dr_sr, dr_cap_c, dr_shifted_c;
  dr_sel_e          dr_sel_c;
  dmi_req_t         dmi_req_c;

  dp_tap_fsm u_tap_fsm (
    .clk          (clk),
    .trst         (trst),
    .tms          (tms),
    .state        (state),
    .capture_ir_c (capture_ir_c),
    .shift_ir_c   (shift_ir_c),
    .update_ir_c  (update_ir_c),
    .capture_dr_c (capture_dr_c),
    .shift_dr_c   (shift_dr_c),
    .update_dr_c  (update_dr_c)
  );

  // Instruction decode; unknown codes fall back to the 1-bit bypass register
  always_comb begin
    dr_sel_c = DR_BYPASS;
    case (ir)
`ifdef DP_DTM_IDCODE_EN
      IR_IDCODE: dr_sel_c = DR_IDCODE;
`endif
      IR_DTMCS:  dr_sel_c = DR_DTMCS;
      IR_DMI:    dr_sel_c = DR_DMI;
      default:   dr_sel_c = DR_BYPASS;
    endcase
  end

  // Capture value and one right shift, tdi entering at the MSB of the selected length
  always_comb begin
    dr_cap_c     = '0;
    dr_shifted_c = '0;
    unique case (dr_sel_c)
      DR_BYPASS: dr_shifted_c[0] = tdi;
      DR_IDCODE: begin
        dr_cap_c     = DMI_W'(IDCODE_VALUE);
        dr_shifted_c = DMI_W'({tdi, dr_sr[DR32_W-1:1]});
      end
      DR_DTMCS: begin
        dr_cap_c     = DMI_W'(DTMCS_VALUE);
        dr_shifted_c = DMI_W'({tdi, dr_sr[DR32_W-1:1]});
      end
      DR_DMI: begin
        dr_cap_c     = DMI_W'({dmi_address, dmi_rdata, 2'b00});
        dr_shifted_c = {tdi, dr_sr[DMI_W-1:1]};
      end
    endcase
  end

  always_ff @(posedge clk or posedge trst) begin
    if (trst) begin
      ir_sr <= '0;
      ir    <= IR_RESET;
      dr_sr <= '0;
    end else begin
      if (capture_ir_c)    ir_sr <= IR_CAPTURE;
      else if (shift_ir_c) ir_sr <= {tdi, ir_sr[IR_W-1:1]};
      if (state == TAP_TLR) ir <= IR_RESET;
      else if (update_ir_c) ir <= ir_sr;
      if (capture_dr_c)    dr_sr <= dr_cap_c;
      else if (shift_dr_c) dr_sr <= dr_shifted_c;
    end
  end

  assign dmi_req_c = dmi_req_t'(dr_sr);

  // Address/data hold until the next DMI update; op is a single-cycle pulse
  always_ff @(posedge clk or posedge trst) begin
    if (trst) begin
      dmi_address <= '0;
      dmi_wdata   <= '0;
      dmi_op      <= 2'b00;
    end else begin
      dmi_op <= 2'b00;
      if (update_dr_c && dr_sel_c == DR_DMI) begin
        dmi_address <= dmi_req_c.address;
        dmi_wdata   <= dmi_req_c.data;
        dmi_op      <= dmi_req_c.op;
      end
    end
  end

  always_ff @(negedge clk or posedge trst) begin
    if (trst)            tdo <= 1'b0;
    else if (shift_ir_c) tdo <= ir_sr[0];
    else if (shift_dr_c) tdo <= dr_sr[0];
    else                 tdo <= 1'b0;
  end

endmodule

// File: tb/tb_dp_dtm.sv
// Directed JTAG scan bench for dp_dtm with DMI read data looped back from write data.
module tb_dp_dtm;

  localparam logic [31:0] IDV = 32'h1000_0CE3;

  logic        clk, trst, tdi, tms, tdo;
  logic [6:0]  dmi_address;
  logic [31:0] dmi_rdata, dmi_wdata;
  logic [1:0]  dmi_op;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] dout;
  logic [4:0]  irout;
  logic [63:0] exp_id;

  dp_dtm #(.IDCODE_VALUE(IDV), .ABITS(7)) dut (
    .clk         (clk),
    .trst        (trst),
    .tdi         (tdi),
    .tms         (tms),
    .tdo         (tdo),
    .dmi_address (dmi_address),
    .dmi_rdata   (dmi_rdata),
    .dmi_wdata   (dmi_wdata),
    .dmi_op      (dmi_op)
  );

  assign dmi_rdata = dmi_wdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic tms_v, input logic tdi_v);
    tms = tms_v;
    tdi = tdi_v;
    @(posedge clk);
    #1;
  endtask

  // RTI -> DR scan -> Update-DR -> RTI; last step is the update edge
  task automatic dr_scan(input int n, input logic [63:0] din, output logic [63:0] q);
    q = '0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i]);
      q[i] = tdo;
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic ir_scan(input logic [4:0] code, output logic [4:0] q);
    q = '0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(i == 4, code[i]);
      q[i] = tdo;
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    trst = 1'b1;
    tms  = 1'b1;
    tdi  = 1'b0;
    #3;
    check("reset_tdo", 64'(tdo), 64'd0);
    check("reset_addr", 64'(dmi_address), 64'd0);
    check("reset_wdata", 64'(dmi_wdata), 64'd0);
    check("reset_op", 64'(dmi_op), 64'd0);
    #9 trst = 1'b0;
    step(1'b0, 1'b0);

    // Reset instruction: IDCODE when enabled, otherwise 1-bit bypass
`ifdef DP_DTM_IDCODE_EN
    exp_id = 64'(IDV);
`else
    exp_id = 64'h1E1E_2468;
`endif
    dr_scan(32, 64'h0F0F_1234, dout);
    check("reset_ir_scan", dout, exp_id);

    ir_scan(5'h00, irout);
    check("ir_capture", 64'(irout), 64'd1);
    dr_scan(32, 64'h0, dout);
    check("bypass0_scan", dout, 64'd0);

    ir_scan(5'h10, irout);
    check("ir_capture_dtmcs", 64'(irout), 64'd1);
    dr_scan(32, 64'hFFFF_FFFF, dout);
    check("dtmcs_scan", dout, 64'h71);

    ir_scan(5'h11, irout);
    dr_scan(41, 64'h1E1_2345_6789, dout);
    check("dmi_write_capture", dout, 64'd0);
    check("dmi_addr", 64'(dmi_address), 64'h78);
    check("dmi_wdata", 64'(dmi_wdata), 64'h48D1_59E2);
    check("dmi_op_pulse", 64'(dmi_op), 64'd1);
    step(1'b0, 1'b0);
    check("dmi_op_clear", 64'(dmi_op), 64'd0);

    // Five tms=1 edges from Shift-DR with DTMCS selected
    ir_scan(5'h10, irout);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("tlr_addr_held", 64'(dmi_address), 64'h78);
    check("tlr_wdata_held", 64'(dmi_wdata), 64'h48D1_59E2);
    check("tlr_op", 64'(dmi_op), 64'd0);
    step(1'b0, 1'b0);
    dr_scan(32, 64'h0F0F_1234, dout);
    check("tlr_ir_scan", dout, exp_id);

    ir_scan(5'h11, irout);
    dr_scan(41, 64'h1E1_2345_6788, dout);
    check("dmi_read_capture", dout, 64'h1E1_2345_6788);
    check("dmi_nop_addr", 64'(dmi_address), 64'h78);
    check("dmi_nop_op", 64'(dmi_op), 64'd0);

    // trst mid Shift-IR while tdo is driving the captured 1
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("shift_ir_tdo", 64'(tdo), 64'd1);
    #2 trst = 1'b1;
    #1;
    check("trst_tdo", 64'(tdo), 64'd0);
    check("trst_addr", 64'(dmi_address), 64'd0);
    check("trst_wdata", 64'(dmi_wdata), 64'd0);
    check("trst_op", 64'(dmi_op), 64'd0);
    #2 trst = 1'b0;
    step(1'b0, 1'b0);
    dr_scan(32, 64'h0F0F_1234, dout);
    check("trst_ir_scan", dout, exp_id);

    ir_scan(5'h05, irout);
    dr_scan(32, 64'hA5A5_A5A5, dout);
    check("undef_ir_bypass", dout, 64'h4B4B_4B4A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
